// File: rtl/attosoc_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : attosoc_bus_pkg
// Description : Shared definitions for the AttoSoC RAM arbiter: FSM state
//               encoding, master identifiers, the default RAM page and a
//               saturating-increment helper for the optional statistics
//               counters.
// Contents    : arb_state_t   - ST_IDLE / ST_ACCESS / ST_RESP
//               M_CPU, M_AUX  - master ids (m0 = CPU, m1 = auxiliary master)
//               RAM_PAGE_DEFAULT, STAT_W, sat_inc()
// Revision    : 1.0 - initial release
// ============================================================================
package attosoc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam logic [7:0] RAM_PAGE_DEFAULT = 8'h00;

  localparam int STAT_W = 16;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage : attosoc_bus_pkg
`default_nettype wire

// File: rtl/attosoc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : attosoc_rr_pick
// Description : Two-input round-robin selector. With a single request the
//               requester wins; with both requesting, the master that was
//               not granted last wins. Purely combinational.
// Ports       : req[1:0] - request vector, bit n = master n
//               last     - id of the most recently granted master
//               gnt_id   - id of the selected master (valid while any=1)
//               any      - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module attosoc_rr_pick
  import attosoc_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       any
);

  always_comb begin
    any    = |req;
    gnt_id = M_CPU;
    case (req)
      2'b01:   gnt_id = M_CPU;
      2'b10:   gnt_id = M_AUX;
      // Contention: ids are one bit wide, so the "other" master is ~last.
      2'b11:   gnt_id = ~last;
      default: gnt_id = M_CPU;
    endcase
  end

endmodule : attosoc_rr_pick
`default_nettype wire

// File: rtl/attosoc_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : attosoc_ram_arbiter
// Description : Round-robin arbiter sharing the single-port SoC block RAM
//               between the PicoRV32 native bus (m0) and an auxiliary bus
//               master (m1). Each transfer walks IDLE -> ACCESS -> RESP, so
//               a request seen in cycle N is acknowledged in cycle N+2.
//               Accesses whose addr[31:24] differs from RAM_PAGE never reach
//               the RAM, return zero data and set the sticky err flag.
// Ports       : clk, resetn                 - clock, async active-low reset
//               m0_* / m1_*                 - native valid/ready master buses
//               ram_en/we/addr/wdata/rdata  - synchronous RAM port (1-cycle
//                                             read latency)
//               err                         - sticky out-of-range flag
//               stat_m0_grants, stat_m1_grants, stat_conflicts
//                                           - saturating grant statistics,
//                                             present only when the macro
//                                             ATTOSOC_ARB_STATS_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module attosoc_ram_arbiter
  import attosoc_bus_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16384,
  parameter int unsigned ADDR_BITS = 14,
  parameter logic [7:0]  RAM_PAGE  = RAM_PAGE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,

  input  logic                 m0_valid,
  output logic                 m0_ready,
  input  logic [31:0]          m0_addr,
  input  logic [31:0]          m0_wdata,
  input  logic [3:0]           m0_wstrb,
  output logic [31:0]          m0_rdata,

  input  logic                 m1_valid,
  output logic                 m1_ready,
  input  logic [31:0]          m1_addr,
  input  logic [31:0]          m1_wdata,
  input  logic [3:0]           m1_wstrb,
  output logic [31:0]          m1_rdata,

  output logic                 ram_en,
  output logic [3:0]           ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,

`ifdef ATTOSOC_ARB_STATS_EN
  output logic [15:0]          stat_m0_grants,
  output logic [15:0]          stat_m1_grants,
  output logic [15:0]          stat_conflicts,
`endif
  output logic                 err
);

  // --------------------------------------------------------------------------
  // Elaboration-time sanity check on the address width
  // --------------------------------------------------------------------------
  if (ADDR_BITS != $clog2(MEM_WORDS)) begin : g_bad_addr_bits
    $error("attosoc_ram_arbiter: ADDR_BITS must equal clog2(MEM_WORDS)");
  end

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  arb_state_t            r_state;
  arb_state_t            w_state_nxt;

  // The id of the master owning the current transfer doubles as the
  // round-robin "last granted" pointer: both are updated on every grant.
  logic                  r_gnt_id;
  logic                  r_in_range;
  logic [ADDR_BITS-1:0]  r_waddr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_err;

  // --------------------------------------------------------------------------
  // Grant selection and request-side muxing
  // --------------------------------------------------------------------------
  logic [1:0]            w_req;
  logic                  w_gnt_id;
  logic                  w_any;
  logic                  w_grant;
  logic [7:0]            w_sel_page;
  logic [ADDR_BITS-1:0]  w_sel_waddr;
  logic [31:0]           w_sel_wdata;
  logic [3:0]            w_sel_wstrb;
  logic [31:0]           w_rdata;

  assign w_req = {m1_valid, m0_valid};

  attosoc_rr_pick u_rr_pick (
    .req    (w_req),
    .last   (r_gnt_id),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  // A grant is taken only from IDLE; this is the single point where
  // master-side inputs are allowed to influence state.
  assign w_grant     = (r_state == ST_IDLE) && w_any;

  assign w_sel_page  = (w_gnt_id == M_AUX) ? m1_addr[31:24]          : m0_addr[31:24];
  assign w_sel_waddr = (w_gnt_id == M_AUX) ? m1_addr[ADDR_BITS+1:2]  : m0_addr[ADDR_BITS+1:2];
  assign w_sel_wdata = (w_gnt_id == M_AUX) ? m1_wdata                : m0_wdata;
  assign w_sel_wstrb = (w_gnt_id == M_AUX) ? m1_wstrb                : m0_wstrb;

  // Address bits that play no part in RAM decode (byte offset, and the gap
  // between the word address and the page byte).
  logic w_unused_lsb;
  assign w_unused_lsb = ^{m0_addr[1:0], m1_addr[1:0]};

  if (ADDR_BITS < 22) begin : g_addr_gap
    logic w_unused_gap;
    assign w_unused_gap = ^{m0_addr[23:ADDR_BITS+2], m1_addr[23:ADDR_BITS+2]};
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and output decode (registered state only, plus the RAM
  // read data that arrives during RESP)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    ram_en      = 1'b0;
    ram_we      = '0;
    ram_addr    = '0;
    ram_wdata   = '0;
    w_rdata     = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // Out-of-range accesses keep the RAM port quiet; err is raised by
        // the register block below.
        if (r_in_range) begin
          ram_en    = 1'b1;
          ram_we    = r_wstrb;
          ram_addr  = r_waddr;
          ram_wdata = r_wdata;
        end
        w_state_nxt = ST_RESP;
      end

      ST_RESP: begin
        // RAM read data is valid now, one cycle after ram_en.
        if (r_in_range && (r_wstrb == 4'b0000)) begin
          w_rdata = ram_rdata;
        end
        if (r_gnt_id == M_AUX) begin
          m1_ready = 1'b1;
          m1_rdata = w_rdata;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = w_rdata;
        end
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Transfer registers, round-robin pointer and sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gnt_id   <= M_AUX;          // so that m0 wins the first tie
      r_in_range <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt_id   <= w_gnt_id;
        r_in_range <= (w_sel_page == RAM_PAGE);
        r_waddr    <= w_sel_waddr;
        r_wdata    <= w_sel_wdata;
        r_wstrb    <= w_sel_wstrb;
      end
      if ((r_state == ST_ACCESS) && !r_in_range) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;

`ifdef ATTOSOC_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Grant statistics, counted on every IDLE -> ACCESS transition
  // --------------------------------------------------------------------------
  logic [STAT_W-1:0] r_stat_m0;
  logic [STAT_W-1:0] r_stat_m1;
  logic [STAT_W-1:0] r_stat_conf;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_m0   <= '0;
      r_stat_m1   <= '0;
      r_stat_conf <= '0;
    end else if (w_grant) begin
      if (w_gnt_id == M_AUX) begin
        r_stat_m1 <= sat_inc(r_stat_m1);
      end else begin
        r_stat_m0 <= sat_inc(r_stat_m0);
      end
      if (&w_req) begin
        r_stat_conf <= sat_inc(r_stat_conf);
      end
    end
  end

  assign stat_m0_grants = r_stat_m0;
  assign stat_m1_grants = r_stat_m1;
  assign stat_conflicts = r_stat_conf;
`endif

endmodule : attosoc_ram_arbiter
`default_nettype wire

// File: tb/tb_attosoc_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_attosoc_ram_arbiter
// Description : Self-checking bench for attosoc_ram_arbiter. A small RAM model
//               sits on the RAM port; expected responses are queued when a
//               request is issued and compared when a ready pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attosoc_ram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        err;
`ifdef ATTOSOC_ARB_STATS_EN
  logic [15:0] stat_m0_grants, stat_m1_grants, stat_conflicts;
`endif

  always #5 clk = ~clk;

  attosoc_ram_arbiter dut (
    .clk       (clk),
    .resetn    (resetn),
    .m0_valid  (m0_valid),
    .m0_ready  (m0_ready),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_rdata  (m0_rdata),
    .m1_valid  (m1_valid),
    .m1_ready  (m1_ready),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_rdata  (m1_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
`ifdef ATTOSOC_ARB_STATS_EN
    .stat_m0_grants (stat_m0_grants),
    .stat_m1_grants (stat_m1_grants),
    .stat_conflicts (stat_conflicts),
`endif
    .err       (err)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mem    [0:63];
  logic [31:0] shadow [0:63];
  logic        preload;

  function automatic logic [31:0] pat(input int i);
    case (i)
      5:       return 32'hDEADBEEF;
      8:       return 32'hAABBCCDD;
      default: return 32'hC0DE_0000 | 32'(i);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RAM model: synchronous, byte write enables, 1-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr[5:0]];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[5:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  // Response monitor: every ready pulse must match the oldest queued request.
  always @(negedge clk) begin
    if (resetn === 1'b1 && (m0_ready || m1_ready)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", {30'b0, m1_ready, m0_ready}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("grant_id",   {31'b0, m1_ready}, {31'b0, mon_e.id});
        chk("both_ready", {31'b0, m0_ready & m1_ready}, 32'h0);
        chk("rdata",      mon_e.id ? m1_rdata : m0_rdata, mon_e.rdata);
        chk("other_rdata", mon_e.id ? m0_rdata : m1_rdata, 32'h0);
      end
    end
  end

  // Issue one transfer from an idle arbiter; caller is at posedge+1.
  task automatic xfer(input logic id, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic drop);
    logic        inr;
    int          w;
    logic [31:0] e;
    int          n;
    int          en_n;
    logic        got;
    logic [3:0]  we_s;
    logic [13:0] a_s;
    logic [31:0] wd_s;
    inr = (addr[31:24] == 8'h00);
    w   = int'(addr[7:2]);
    e   = (inr && wstrb == 4'b0) ? shadow[w] : 32'h0;
    if (inr)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) shadow[w][b*8 +: 8] = wdata[b*8 +: 8];
    sb.push_back('{id, e});
    if (id) begin
      m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end else begin
      m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end
    n = 0; en_n = 0; got = 1'b0; we_s = '0; a_s = '0; wd_s = '0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (ram_en) en_n++;
      if (n == 2) begin
        we_s = ram_we; a_s = ram_addr; wd_s = ram_wdata;
        if (drop) begin
          if (id) m1_valid = 1'b0; else m0_valid = 1'b0;
        end
      end
      got = id ? m1_ready : m0_ready;
    end
    chk("latency", 32'(n), 32'd3);
    chk("ram_en_cycles", 32'(en_n), inr ? 32'd1 : 32'd0);
    chk("ram_we", {28'b0, we_s}, inr ? {28'b0, wstrb} : 32'h0);
    if (inr) begin
      chk("ram_addr", {18'b0, a_s}, {18'b0, addr[15:2]});
      chk("ram_wdata", wd_s, wdata);
    end
    @(posedge clk); #1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
  endtask

  initial begin
    int nready;
    int ncyc;
    resetn  = 1'b0;
    preload = 1'b1;
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    for (int i = 0; i < 64; i++) shadow[i] = pat(i);
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;

    // Reset state
    chk("rst_ram_en",    {31'b0, ram_en}, 32'h0);
    chk("rst_ram_we",    {28'b0, ram_we}, 32'h0);
    chk("rst_ram_addr",  {18'b0, ram_addr}, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_m0_ready",  {31'b0, m0_ready}, 32'h0);
    chk("rst_m1_ready",  {31'b0, m1_ready}, 32'h0);
    chk("rst_m0_rdata",  m0_rdata, 32'h0);
    chk("rst_m1_rdata",  m1_rdata, 32'h0);
    chk("rst_err",       {31'b0, err}, 32'h0);
    resetn = 1'b1;

    // Single read, byte write, read-back
    xfer(1'b0, 32'h0000_0014, 32'h0, 4'b0000, 1'b0);
    xfer(1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0010, 1'b0);
    xfer(1'b0, 32'h0000_0020, 32'h0, 4'b0000, 1'b0);
    chk("byte_write_mem", mem[8], 32'hAABB33DD);

    // Contention from reset: strict alternation, one transfer every 3 cycles
    resetn = 1'b0;
    sb.delete();
    m0_valid = 1'b1; m0_addr = 32'h14; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 1'b1; m1_addr = 32'h20; m1_wdata = 0; m1_wstrb = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) sb.push_back('{k[0], k[0] ? shadow[8] : shadow[5]});
    nready = 0;
    ncyc   = 0;
    while (nready < 6 && ncyc < 40) begin
      @(negedge clk);
      ncyc++;
      if (m0_ready || m1_ready) begin
        nready++;
        chk("cont_ready_cycle", 32'(ncyc), 32'(3 * nready));
      end
    end
    chk("cont_transfers", 32'(nready), 32'd6);
    @(posedge clk); #1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    chk("cont_sb_empty", 32'(sb.size()), 32'd0);
`ifdef ATTOSOC_ARB_STATS_EN
    chk("stat_conflicts", {16'b0, stat_conflicts}, 32'd6);
    chk("stat_m0_grants", {16'b0, stat_m0_grants}, 32'd3);
    chk("stat_m1_grants", {16'b0, stat_m1_grants}, 32'd3);
`endif

    // Out of range, then err stays set through in-range traffic
    chk("err_before_oor", {31'b0, err}, 32'h0);
    xfer(1'b0, 32'h0300_0000, 32'h0, 4'b0000, 1'b0);
    chk("err_after_oor", {31'b0, err}, 32'h1);
    xfer(1'b1, 32'h0000_0014, 32'h0, 4'b0000, 1'b0);
    chk("err_sticky", {31'b0, err}, 32'h1);

    // Reset asserted during ACCESS of an m1 write
    m1_valid = 1'b1; m1_addr = 32'h30; m1_wdata = 32'h55AA_55AA; m1_wstrb = 4'hF;
    @(posedge clk); #2;
    chk("rma_in_access", {31'b0, ram_en}, 32'h1);
    resetn   = 1'b0;
    m1_valid = 1'b0;
    sb.delete();
    #1;
    chk("rma_ram_en",   {31'b0, ram_en}, 32'h0);
    chk("rma_ram_we",   {28'b0, ram_we}, 32'h0);
    chk("rma_m1_ready", {31'b0, m1_ready}, 32'h0);
    chk("rma_err",      {31'b0, err}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rma_no_write", mem[12], shadow[12]);
    resetn = 1'b1;
    xfer(1'b0, 32'h0000_0030, 32'h0, 4'b0000, 1'b0);

    // m1 drops valid during ACCESS; next request in the following cycle
    xfer(1'b1, 32'h0000_0030, 32'h1234_5678, 4'hF, 1'b1);
    chk("drop_mem", mem[12], 32'h1234_5678);
    xfer(1'b0, 32'h0000_0030, 32'h0, 4'b0000, 1'b0);

    repeat (2) @(posedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_attosoc_ram_arbiter
`default_nettype wire

// File: doc/attosoc_ram_arbiter.md
Name: attosoc_ram_arbiter

Overview:
- Two-master round-robin arbiter that shares the single-port SoC block RAM between the PicoRV32 native memory bus (m0) and a second bus master such as a DMA or debug loader (m1).
- Both masters use the valid/ready native-bus handshake.
- RAM side is a synchronous, byte-write-enabled, single-port array with 1-cycle read latency.
- Sits between the masters and the RAM inside the SoC top; I/O decode stays outside this block.

Parameters:
- MEM_WORDS, 16384, RAM depth in 32-bit words.
- ADDR_BITS, 14, RAM word-address width; must equal clog2(MEM_WORDS).
- RAM_PAGE, 8'h00, required value of addr[31:24] for an in-range access.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  master 0 request (CPU)
- m0_ready  out  1  master 0 transfer complete, single-cycle pulse
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0 = read
- m0_rdata  out  32  master 0 read data, valid while m0_ready=1
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata  as m0, for master 1
- ram_en  out  1  RAM access enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  ADDR_BITS  RAM word address, taken from addr[ADDR_BITS+1:2]
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, 1 cycle after ram_en
- err  out  1  sticky flag: an out-of-range access occurred

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample m0_valid and m1_valid.
  - If exactly one is asserted, grant it.
  - If both are asserted, grant the master not granted last. The last-grant pointer resets to m1, so m0 wins the first tie.
  - Register the granted master's addr, wdata, wstrb and id, update the pointer, and go to ACCESS.
  - If neither is asserted, stay in IDLE.
- ACCESS:
  - In range (addr[31:24]==RAM_PAGE): drive ram_en=1, ram_we=registered wstrb, ram_addr, ram_wdata.
  - Out of range: ram_en=0, ram_we=0, set err.
  - Always go to RESP.
- RESP:
  - Granted master's ready=1 for exactly one cycle.
  - rdata = ram_rdata for an in-range read; 32'h0 for a write or an out-of-range access.
  - Non-granted master: ready=0, rdata=0.
  - Go to IDLE.
- Latency: valid seen in cycle N gives ready in cycle N+2. Minimum 3 cycles per transfer. With both masters continuously requesting, grants strictly alternate.
- Masters must hold valid/addr/wdata/wstrb until ready and deassert after it.
  - If valid drops mid-transfer, the transfer still completes, including any RAM write, and the ready pulse is issued regardless.
  - A valid still high in the IDLE cycle after RESP is a new request.
- All outputs are combinational decodes of registered state. There is no combinational path from m*_valid to m*_ready or to ram_*.
- Reset values: state=IDLE, m0_ready=m1_ready=0, rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, err=0, pointer=m1.
- Reset asserted mid-transfer: the transfer is aborted immediately; no ready is issued and no RAM write occurs after reset assertion.
- err clears only on reset.

Optional Feature:
- Macro: ATTOSOC_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_m0_grants [15:0], stat_m1_grants [15:0] and stat_conflicts [15:0].
  - Each is a saturating counter (stops at 16'hFFFF) incremented on the IDLE->ACCESS transition: per granted master, and stat_conflicts when both valids were high.
  - All reset to 0.
- When undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package attosoc_bus_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - master id constants M_CPU=1'b0, M_AUX=1'b1;
  - the RAM_PAGE default.
- One sub-module, attosoc_rr_pick: a 2-input round-robin selector taking req[1:0] and last, returning gnt_id and any. It is combinational.
- FSM, registers and counters stay in the top module.

Test Plan:
- Single read: RAM word 5 = 32'hDEADBEEF; m0 reads 32'h0000_0014 -> ram_en one cycle with ram_addr=5, m0_ready one cycle at N+2, m0_rdata=32'hDEADBEEF, m1_ready stays 0.
- Byte write: m1 writes addr 32'h0000_0020, wdata 32'h1122_3344, wstrb 4'b0010 -> ram_we=4'b0010, ram_addr=8; a subsequent read returns only byte 1 = 8'h33 changed.
- Contention: m0 and m1 both hold valid continuously from reset for 6 transfers -> grant order m0,m1,m0,m1,m0,m1; each transfer takes 3 cycles; with stats enabled stat_conflicts=6 and stat_m0_grants=stat_m1_grants=3.
- Out of range: m0 reads 32'h0300_0000 -> ram_en stays 0, m0_ready pulses with m0_rdata=0, err=1 and stays 1 through later in-range traffic.
- Reset mid-access: assert resetn=0 during ACCESS of an m1 write -> all outputs zero immediately, no m1_ready; after release, an m0 request is granted first and completes normally.
- Valid drop: m1 deasserts valid during ACCESS of a write -> RAM write still occurs and m1_ready still pulses in RESP; the arbiter is back in IDLE the next cycle.
